// File: rtl/dmem_responder.sv
// Data-memory responder: accepts LSU load/store requests, accesses on-chip RAM and returns
// in-order formatted responses through a credit-limited response FIFO with flush support.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int MEM_DEPTH  = 1024,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [TAG_WIDTH-1:0]  i_req_tag,
    input  logic [PREG_WIDTH-1:0] i_req_prd,
    input  logic                  i_flush,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [TAG_WIDTH-1:0]  o_rsp_tag,
    output logic [PREG_WIDTH-1:0] o_rsp_prd,
    output logic                  o_rsp_store,
    output logic                  o_rsp_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                  err;
        logic                  store;
        logic [PREG_WIDTH-1:0] prd;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  inf_valid_q, inf_valid_d;
    logic [1:0]            inf_off_q, inf_off_d;
    logic [2:0]            inf_f3_q, inf_f3_d;
    logic                  inf_store_q, inf_store_d;
    logic                  inf_err_q, inf_err_d;
    logic [TAG_WIDTH-1:0]  inf_tag_q, inf_tag_d;
    logic [PREG_WIDTH-1:0] inf_prd_q, inf_prd_d;

    rsp_t                  fifo_q [RSP_DEPTH];
    rsp_t                  fifo_d [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [CNT_W-1:0]      occupancy;
    logic                  acc;
    logic                  wr_en;
    logic                  req_err;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wd;
    logic [IDX_W-1:0]      req_idx;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    rsp_t                  push_ent;
    rsp_t                  head;
    logic                  push;
    logic                  pop;

    // The credit counts the in-flight slot so a push can never find the FIFO full.
    assign occupancy   = count_q + CNT_W'(inf_valid_q);
    assign o_req_ready = reset && !i_flush && (occupancy < CNT_W'(RSP_DEPTH));
    assign acc         = i_req_valid && o_req_ready;
    assign req_idx     = i_req_addr[IDX_W+1:2];
    assign wr_en       = acc && i_req_we && !req_err;

    always_comb begin
        req_err = 1'b0;
        req_be  = 4'b0000;
        req_wd  = i_req_wdata;
        case (i_req_funct3)
            3'b000, 3'b100: begin
                req_be = 4'b0001 << i_req_addr[1:0];
                req_wd = {4{i_req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                req_err = i_req_addr[0];
                req_be  = i_req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd  = {2{i_req_wdata[15:0]}};
            end
            3'b010: begin
                req_err = (i_req_addr[1:0] != 2'b00);
                req_be  = 4'b1111;
            end
            default: req_err = 1'b1;
        endcase
        if ((i_req_addr >> (IDX_W + 2)) != '0) begin
            req_err = 1'b1;
        end
    end

    // RAM has no reset; the read is unconditional and only consumed for accepted loads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem_q[req_idx][8*b +: 8] <= req_wd[8*b +: 8];
                end
            end
        end
        rdata_q <= mem_q[req_idx];
    end

    always_comb begin
        inf_valid_d = acc;
        inf_off_d   = inf_off_q;
        inf_f3_d    = inf_f3_q;
        inf_store_d = inf_store_q;
        inf_err_d   = inf_err_q;
        inf_tag_d   = inf_tag_q;
        inf_prd_d   = inf_prd_q;
        if (acc) begin
            inf_off_d   = i_req_addr[1:0];
            inf_f3_d    = i_req_funct3;
            inf_store_d = i_req_we;
            inf_err_d   = req_err;
            inf_tag_d   = i_req_tag;
            inf_prd_d   = i_req_prd;
        end
    end

    always_comb begin
        ld_byte  = rdata_q[{inf_off_q, 3'b000} +: 8];
        ld_half  = inf_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        push_ent = '0;
        push_ent.err   = inf_err_q;
        push_ent.store = inf_store_q;
        push_ent.tag   = inf_tag_q;
        push_ent.prd   = inf_prd_q;
        if (!inf_err_q && !inf_store_q) begin
            case (inf_f3_q)
                3'b000:  push_ent.data = {{24{ld_byte[7]}}, ld_byte};
                3'b001:  push_ent.data = {{16{ld_half[15]}}, ld_half};
                3'b010:  push_ent.data = rdata_q;
                3'b100:  push_ent.data = {24'd0, ld_byte};
                3'b101:  push_ent.data = {16'd0, ld_half};
                default: push_ent.data = '0;
            endcase
        end
    end

    assign push = inf_valid_q;
    assign pop  = o_rsp_valid && i_rsp_ready;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = push_ent;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inf_valid_q <= 1'b0;
            inf_off_q   <= '0;
            inf_f3_q    <= '0;
            inf_store_q <= 1'b0;
            inf_err_q   <= 1'b0;
            inf_tag_q   <= '0;
            inf_prd_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            inf_valid_q <= inf_valid_d && !i_flush;
            inf_off_q   <= inf_off_d;
            inf_f3_q    <= inf_f3_d;
            inf_store_q <= inf_store_d;
            inf_err_q   <= inf_err_d;
            inf_tag_q   <= inf_tag_d;
            inf_prd_q   <= inf_prd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_q      <= fifo_d;
        end
    end

    // Head fields are forced to zero whenever the FIFO is empty, including during reset.
    assign head        = fifo_q[rd_ptr_q];
    assign o_rsp_valid = (count_q != '0);
    assign o_rsp_data  = o_rsp_valid ? head.data  : '0;
    assign o_rsp_tag   = o_rsp_valid ? head.tag   : '0;
    assign o_rsp_prd   = o_rsp_valid ? head.prd   : '0;
    assign o_rsp_store = o_rsp_valid ? head.store : 1'b0;
    assign o_rsp_err   = o_rsp_valid ? head.err   : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses,
// a negedge monitor pops and compares every consumed response.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = '0;
    logic [3:0]  i_req_tag = '0;
    logic [6:0]  i_req_prd = '0;
    logic        i_flush = 1'b0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b1;
    logic [31:0] o_rsp_data;
    logic [3:0]  o_rsp_tag;
    logic [6:0]  o_rsp_prd;
    logic        o_rsp_store;
    logic        o_rsp_err;

    typedef struct packed {
        logic        err;
        logic        store;
        logic [6:0]  prd;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    logic [3:0] next_tag = '0;
    logic [3:0] first_tag;

    dmem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_tag    (i_req_tag),
        .i_req_prd    (i_req_prd),
        .i_flush      (i_flush),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_tag    (o_rsp_tag),
        .o_rsp_prd    (o_rsp_prd),
        .o_rsp_store  (o_rsp_store),
        .o_rsp_err    (o_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        chk_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    // Handshake happens at the posedge following a negedge where valid && ready.
    always @(negedge clk) begin
        exp_t e;
        if (reset && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_rsp: got tag %h data %h want no response", o_rsp_tag, o_rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("rsp", 64'({o_rsp_err, o_rsp_store, o_rsp_prd, o_rsp_tag, o_rsp_data}), 64'(e));
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] edata, input logic eerr);
        exp_t e;
        bit   ok = 1'b0;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        i_req_tag    = next_tag;
        i_req_prd    = {3'b101, next_tag};
        e.err   = eerr;
        e.store = we;
        e.prd   = {3'b101, next_tag};
        e.tag   = next_tag;
        e.data  = (eerr || we) ? 32'd0 : edata;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (o_req_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        i_req_valid = 1'b0;
        if (!ok) begin
            chk_cnt++;
            $display("FAIL req_timeout: tag %0d got not accepted want accepted", next_tag);
        end
        next_tag++;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_ready", 64'(o_req_ready), 64'd0);
        check("reset_valid", 64'(o_rsp_valid), 64'd0);
        check("reset_fields", 64'({o_rsp_err, o_rsp_store, o_rsp_prd, o_rsp_tag, o_rsp_data}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("ready_after_reset", 64'(o_req_ready), 64'd1);

        // store then load of the same word
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        wait_drain();

        // sub-word store and sign/zero-extended loads
        do_req(1, 3'b000, 32'h13, 32'h00000080, 32'h0, 0);
        do_req(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        do_req(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0);
        do_req(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        do_req(0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 0);
        do_req(0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0);
        do_req(0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
        wait_drain();

        // error cases leave RAM untouched
        do_req(0, 3'b010, 32'h12, 32'h0, 32'h0, 1);
        do_req(1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0, 1);
        do_req(0, 3'b010, 32'h1000, 32'h0, 32'h0, 1);
        do_req(0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
        do_req(1, 3'b010, 32'h1010, 32'h0, 32'h0, 1);
        do_req(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        do_req(1, 3'b010, 32'h14, 32'h11111111, 32'h0, 0);
        do_req(1, 3'b001, 32'h16, 32'hABCD1234, 32'h0, 0);
        do_req(0, 3'b010, 32'h14, 32'h0, 32'h12341111, 0);
        do_req(0, 3'b001, 32'h16, 32'h0, 32'h00001234, 0);
        do_req(1, 3'b000, 32'h14, 32'h000000F0, 32'h0, 0);
        do_req(0, 3'b000, 32'h14, 32'h0, 32'hFFFFFFF0, 0);
        do_req(0, 3'b101, 32'h14, 32'h0, 32'h000011F0, 0);
        wait_drain();

        // credit back-pressure with the consumer stalled
        i_rsp_ready = 1'b0;
        first_tag = next_tag;
        do_req(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        do_req(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0);
        do_req(0, 3'b101, 32'h16, 32'h0, 32'h00001234, 0);
        do_req(0, 3'b010, 32'h14, 32'h0, 32'h123411F0, 0);
        repeat (2) @(negedge clk);
        check("ready_full", 64'(o_req_ready), 64'd0);
        check("head_tag_stalled", 64'(o_rsp_tag), 64'(first_tag));
        check("head_data_stalled", 64'(o_rsp_data), 64'h80ADBEEF);
        @(posedge clk);
        #1;
        fork
            begin
                do_req(0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAD, 0);
                do_req(0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                i_rsp_ready = 1'b1;
            end
        join
        wait_drain();

        // flush with three queued and one in flight
        i_rsp_ready = 1'b0;
        do_req(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        do_req(0, 3'b010, 32'h14, 32'h0, 32'h123411F0, 0);
        do_req(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        do_req(0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0);
        i_flush = 1'b1;
        #1;
        check("ready_during_flush", 64'(o_req_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        #1;
        check("valid_after_flush", 64'(o_rsp_valid), 64'd0);
        check("ready_after_flush", 64'(o_req_ready), 64'd1);
        repeat (2) @(negedge clk);
        check("no_leak_after_flush", 64'(o_rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b1;
        do_req(0, 3'b010, 32'h14, 32'h0, 32'h123411F0, 0);
        wait_drain();

        // asynchronous reset mid-stream
        i_rsp_ready = 1'b0;
        do_req(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0);
        do_req(0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0);
        repeat (2) @(posedge clk);
        #3;
        check("valid_before_reset", 64'(o_rsp_valid), 64'd1);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("valid_in_reset", 64'(o_rsp_valid), 64'd0);
        check("fields_in_reset", 64'({o_rsp_err, o_rsp_store, o_rsp_prd, o_rsp_tag, o_rsp_data}), 64'd0);
        check("ready_in_reset", 64'(o_req_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_rsp_ready = 1'b1;
        #1;
        check("valid_after_release", 64'(o_rsp_valid), 64'd0);
        do_req(0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0);
        do_req(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
